keccak_round_sequencer: RTL and testbench

Parametrised round sequencer for the Keccak-f/Keccak-p permutation datapath. It drives the step enables (theta/colParity, rho/rotate, pi/permute, chi/revalute, iota/addRC), the state-load strobe and the round-constant index. Its round counter is internal. Round count is selectable per operation, and a compile-time mode fuses all five steps into one cycle. Results are handed out on a valid/ready handshake. It replaces the fixed 24-round, externally counted controller.

---
 rtl/keccak_round_sequencer.sv | 126 ++++++++++++
 tb/tb_keccak_round_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_round_sequencer.sv
// Keccak-f/p round sequencer: step enables, load strobe and rc_idx from an internal round counter (abort port via KECCAK_SEQ_ABORT_EN).
// Latency 2+5*nr cycles (2+nr when FUSED) from start to out_valid; the result is held in OUT until out_ready.
module keccak_round_sequencer #(
  parameter int MAX_ROUNDS = 24,
  parameter int ROUND_W    = 5,
  parameter int FUSED      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ROUND_W-1:0] num_rounds,
  output logic               busy,
  output logic               load_en,
  output logic               colParity_en,
  output logic               rotate_en,
  output logic               permute_en,
  output logic               revalute_en,
  output logic               addRC_en,
  output logic [ROUND_W-1:0] rc_idx,
  output logic               out_valid,
  input  logic               out_ready
`ifdef KECCAK_SEQ_ABORT_EN
  ,
  input  logic               abort
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_THETA, S_RHO, S_PI, S_CHI, S_IOTA, S_ROUND, S_OUT
  } state_e;

  localparam logic [ROUND_W-1:0] MAX_NR     = ROUND_W'(MAX_ROUNDS);
  localparam logic [ROUND_W-1:0] ONE        = ROUND_W'(1);
  localparam state_e             FIRST_STEP = (FUSED != 0) ? S_ROUND : S_THETA;

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] r_q, r_d;
  logic [ROUND_W-1:0] nr_q, nr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      nr_q    <= MAX_NR;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      nr_q    <= nr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    nr_d    = nr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          r_d     = '0;
          // Out-of-range requests fall back to the native round count.
          nr_d    = (num_rounds == '0 || num_rounds > MAX_NR) ? MAX_NR : num_rounds;
        end
      end
      S_LOAD:  state_d = FIRST_STEP;
      S_THETA: state_d = S_RHO;
      S_RHO:   state_d = S_PI;
      S_PI:    state_d = S_CHI;
      S_CHI:   state_d = S_IOTA;
      S_IOTA, S_ROUND: begin
        if (r_q == nr_q - ONE) begin
          state_d = S_OUT;
          r_d     = '0;
        end else begin
          state_d = FIRST_STEP;
          r_d     = r_q + ONE;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef KECCAK_SEQ_ABORT_EN
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      r_d     = '0;
    end
`endif
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    load_en      = 1'b0;
    colParity_en = 1'b0;
    rotate_en    = 1'b0;
    permute_en   = 1'b0;
    revalute_en  = 1'b0;
    addRC_en     = 1'b0;
    out_valid    = 1'b0;
    rc_idx       = '0;
    case (state_q)
      S_LOAD:  load_en      = 1'b1;
      S_THETA: colParity_en = 1'b1;
      S_RHO:   rotate_en    = 1'b1;
      S_PI:    permute_en   = 1'b1;
      S_CHI:   revalute_en  = 1'b1;
      S_IOTA: begin
        addRC_en = 1'b1;
        rc_idx   = (MAX_NR - nr_q) + r_q;
      end
      S_ROUND: begin
        colParity_en = 1'b1;
        rotate_en    = 1'b1;
        permute_en   = 1'b1;
        revalute_en  = 1'b1;
        addRC_en     = 1'b1;
        // Reduced-round Keccak-p uses the tail of the constant table.
        rc_idx       = (MAX_NR - nr_q) + r_q;
      end
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Bench for keccak_round_sequencer: one-step-per-cycle and fused instances share stimulus, each against a schedule model.
module tb_keccak_round_sequencer;
  localparam int MAXR = 24;
  localparam int RW   = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic [RW-1:0] num_rounds;
`ifdef KECCAK_SEQ_ABORT_EN
  logic          abort;
`endif
  logic [1:0]    busy, load_en, colParity_en, rotate_en, permute_en, revalute_en, addRC_en, out_valid;
  logic [RW-1:0] rc_idx [2];

  always #5 clk = ~clk;

  keccak_round_sequencer #(.MAX_ROUNDS(MAXR), .ROUND_W(RW), .FUSED(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rounds(num_rounds),
    .busy(busy[0]), .load_en(load_en[0]), .colParity_en(colParity_en[0]),
    .rotate_en(rotate_en[0]), .permute_en(permute_en[0]), .revalute_en(revalute_en[0]),
    .addRC_en(addRC_en[0]), .rc_idx(rc_idx[0]), .out_valid(out_valid[0]), .out_ready(out_ready)
`ifdef KECCAK_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  keccak_round_sequencer #(.MAX_ROUNDS(MAXR), .ROUND_W(RW), .FUSED(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rounds(num_rounds),
    .busy(busy[1]), .load_en(load_en[1]), .colParity_en(colParity_en[1]),
    .rotate_en(rotate_en[1]), .permute_en(permute_en[1]), .revalute_en(revalute_en[1]),
    .addRC_en(addRC_en[1]), .rc_idx(rc_idx[1]), .out_valid(out_valid[1]), .out_ready(out_ready)
`ifdef KECCAK_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Schedule model: an operation is just "cycles since start was taken";
  // cycle 1 loads, cycles 2..1+nr*S run the steps, then the result waits.
  int m_active [2];
  int m_off    [2];
  int m_nr     [2];

  function automatic int spr(int i);
    return (i == 0) ? 5 : 1;
  endfunction

  function automatic logic [12:0] expv(int i);
    logic [12:0] v;
    int s, k, p;
    v = '0;
    s = spr(i);
    if (m_active[i] == 0) return v;
    v[12] = 1'b1;
    if (m_off[i] == 1) v[11] = 1'b1;
    else if (m_off[i] < 2 + m_nr[i] * s) begin
      k = (m_off[i] - 2) / s;
      p = (m_off[i] - 2) % s;
      if (s == 1) v[10:6] = 5'b11111;
      else v[10 - p] = 1'b1;
      if (v[6]) v[4:0] = 5'(MAXR - m_nr[i] + k);
    end else v[5] = 1'b1;
    return v;
  endfunction

  function automatic logic [12:0] actv(int i);
    return {busy[i], load_en[i], colParity_en[i], rotate_en[i], permute_en[i],
            revalute_en[i], addRC_en[i], out_valid[i], rc_idx[i]};
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (actv(i) !== expv(i)) begin
        errors++;
        $display("FAIL %s inst%0d t=%0t: got busy/load/en5/ov/rc=%b required %b",
                 tag, i, $time, actv(i), expv(i));
      end
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", tag, got, want);
    end
  endtask

  task automatic model_edge();
    logic ab;
    ab = 1'b0;
`ifdef KECCAK_SEQ_ABORT_EN
    ab = abort;
`endif
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) m_active[i] = 0;
      else if (m_active[i] == 0) begin
        if (start) begin
          m_active[i] = 1;
          m_off[i]    = 1;
          m_nr[i]     = (num_rounds == 0 || num_rounds > MAXR) ? MAXR : int'(num_rounds);
        end
      end else if (ab) m_active[i] = 0;
      else if (m_off[i] >= 2 + m_nr[i] * spr(i)) begin
        if (out_ready) m_active[i] = 0;
      end else m_off[i]++;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300 && (m_active[0] != 0 || m_active[1] != 0); n++) step("drain");
    check_val("drain_timeout", m_active[0] + m_active[1], 0);
  endtask

  typedef struct {
    logic [RW-1:0] nr_in;
    int            out_cyc0;
    int            out_cyc1;
    int            rc_first;
  } vec_t;

  vec_t tbl [6];

  task automatic run_vec(input vec_t v, input int idx);
    int got0, got1, rc0;
    wait_idle();
    out_ready  = 1'b1;
    num_rounds = v.nr_in;
    start      = 1'b1;
    step("vec_start");
    start = 1'b0;
    got0 = -1; got1 = -1; rc0 = -1;
    for (int c = 1; c < 200; c++) begin
      if (out_valid[0] && got0 < 0) got0 = c;
      if (out_valid[1] && got1 < 0) got1 = c;
      if (addRC_en[0] && rc0 < 0) rc0 = int'(rc_idx[0]);
      if (got0 >= 0 && got1 >= 0) break;
      step("vec_run");
    end
    check_val($sformatf("vec%0d_outcyc_f0", idx), got0, v.out_cyc0);
    check_val($sformatf("vec%0d_outcyc_f1", idx), got1, v.out_cyc1);
    check_val($sformatf("vec%0d_rc_first", idx), rc0, v.rc_first);
  endtask

  initial begin
    int ov_cnt;
    tbl[0] = '{5'd24, 122, 26, 0};
    tbl[1] = '{5'd12, 62, 14, 12};
    tbl[2] = '{5'd0, 122, 26, 0};
    tbl[3] = '{5'd30, 122, 26, 0};
    tbl[4] = '{5'd1, 7, 3, 23};
    tbl[5] = '{5'd31, 122, 26, 0};

    for (int i = 0; i < 2; i++) begin m_active[i] = 0; m_off[i] = 0; m_nr[i] = MAXR; end
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; num_rounds = '0;
`ifdef KECCAK_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check_all("reset");
    #10 rst_n = 1'b1;
    for (int n = 0; n < 10; n++) step("idle");

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Backpressure: hold out_ready low, pulse start while waiting.
    wait_idle();
    out_ready = 1'b0; num_rounds = 5'd2; start = 1'b1;
    step("bp_start");
    start = 1'b0;
    for (int n = 0; n < 100 && !out_valid[0]; n++) step("bp_run");
    ov_cnt = 0;
    for (int n = 0; n < 7; n++) begin
      if (out_valid[0] && busy[0]) ov_cnt++;
      start = n[0];
      step("bp_hold");
    end
    start = 1'b0;
    check_val("bp_held_cycles", ov_cnt, 7);
    out_ready = 1'b1;
    step("bp_release");
    check_val("bp_idle_after_ready", int'(busy[0]), 0);
    start = 1'b1; num_rounds = 5'd3;
    step("bp_restart");
    start = 1'b0;
    check_val("bp_restart_load", int'(load_en[0]), 1);

    // Asynchronous reset in round 5.
    wait_idle();
    num_rounds = 5'd24; start = 1'b1;
    step("rst_start");
    start = 1'b0;
    for (int n = 0; n < 100 && m_off[0] != 28; n++) step("rst_run");
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin m_active[i] = 0; check_val($sformatf("rst_async_inst%0d", i), int'(actv(i)), 0); end
    #2 rst_n = 1'b1;
    step("rst_after");
    run_vec(tbl[0], 9);

`ifdef KECCAK_SEQ_ABORT_EN
    wait_idle();
    num_rounds = 5'd24; start = 1'b1;
    step("ab_start");
    start = 1'b0;
    for (int n = 0; n < 100 && m_off[0] != 19; n++) step("ab_run");
    check_val("ab_in_pi", int'(permute_en[0]), 1);
    abort = 1'b1;
    step("ab_edge");
    abort = 1'b0;
    check_val("ab_idle", int'(busy[0]), 0);
    for (int n = 0; n < 130; n++) step("ab_after");
`endif

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom % 4) == 0;
      num_rounds = RW'($urandom % 32);
      out_ready  = ($urandom % 3) != 0;
`ifdef KECCAK_SEQ_ABORT_EN
      abort      = ($urandom % 64) == 0;
`endif
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
